// File: rtl/demux_regbank.sv
// Write demultiplexer into a bank of N_CH registers with valid/ready handshake,
// auto-increment bursts with wrap, per-channel clear and a clear-all sweep.
module demux_regbank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 10,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic                     burst_start,
  input  logic [SEL_W-1:0]         burst_len,
  input  logic [N_CH-1:0]          clr_ch,
  input  logic                     clr_all,
  output logic [N_CH*DATA_W-1:0]   regs,
  output logic [N_CH-1:0]          ch_valid,
  output logic                     burst_busy,
  output logic                     sel_err
);

  typedef enum logic [1:0] {StIdle, StBurst, StSweep} state_e;

  // One extra bit so N_CH == 2^SEL_W still compares correctly.
  localparam logic [SEL_W:0]   NChW   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] One    = SEL_W'(1);

  state_e                        state_q;
  logic [N_CH-1:0][DATA_W-1:0]   regs_q;
  logic [N_CH-1:0]               valid_q;
  logic [SEL_W-1:0]              ptr_q;
  logic [SEL_W-1:0]              cnt_q;
  logic [SEL_W-1:0]              sc_q;
  logic                          err_q;
  logic                          sel_ok;
  logic                          accept;

  assign sel_ok = {1'b0, wr_sel} < NChW;

  always_comb begin
    wr_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle:  wr_ready = !(burst_start || clr_all);
        StBurst: wr_ready = !clr_all;
        default: wr_ready = 1'b0;
      endcase
    end
  end

  assign accept = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      regs_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_all) begin
            state_q <= StSweep;
            sc_q    <= '0;
          end else if (burst_start) begin
            if (sel_ok && (burst_len != '0)) begin
              state_q <= StBurst;
              ptr_q   <= wr_sel;
              cnt_q   <= burst_len;
            end else begin
              err_q <= 1'b1;
            end
          end else if (accept) begin
            if (sel_ok) begin
              regs_q[wr_sel]  <= wr_data;
              valid_q[wr_sel] <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StBurst: begin
          if (clr_all) begin
            state_q <= StSweep;
            sc_q    <= '0;
          end else if (accept) begin
            regs_q[ptr_q]  <= wr_data;
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= (ptr_q == LastCh) ? '0 : ptr_q + One;
            cnt_q          <= cnt_q - One;
            if (cnt_q == One) state_q <= StIdle;
          end
        end
        StSweep: begin
          regs_q[sc_q]  <= '0;
          valid_q[sc_q] <= 1'b0;
          if (sc_q == LastCh) state_q <= StIdle;
          else                sc_q    <= sc_q + One;
        end
        default: state_q <= StIdle;
      endcase
      // Later assignments win, so a clear beats a same-edge write.
      for (int k = 0; k < N_CH; k++) begin
        if (clr_ch[k]) begin
          regs_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign regs       = regs_q;
  assign ch_valid   = valid_q;
  assign burst_busy = (state_q == StBurst);
  assign sel_err    = err_q;

endmodule

// File: tb/tb_demux_regbank.sv
// Bench for demux_regbank: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_demux_regbank;

  localparam int DW = 8;
  localparam int NC = 10;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [DW-1:0]     wr_data;
  logic [SW-1:0]     wr_sel;
  logic              burst_start;
  logic [SW-1:0]     burst_len;
  logic [NC-1:0]     clr_ch;
  logic              clr_all;
  logic [NC*DW-1:0]  regs;
  logic [NC-1:0]     ch_valid;
  logic              burst_busy;
  logic              sel_err;

  demux_regbank #(.DATA_W(DW), .N_CH(NC), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_sel(wr_sel), .burst_start(burst_start),
    .burst_len(burst_len), .clr_ch(clr_ch), .clr_all(clr_all), .regs(regs),
    .ch_valid(ch_valid), .burst_busy(burst_busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: pending burst targets as a queue, sweep as cycles left.
  logic [DW-1:0] m_regs [NC];
  logic [NC-1:0] m_valid = '0;
  logic          m_err = 1'b0;
  int            burst_q[$];
  int            sweep_left = 0;
  logic          ready_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] model_regs();
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = m_regs[k];
    return v;
  endfunction

  task automatic m_write(input int ch, input logic [DW-1:0] d);
    m_regs[ch]  = d;
    m_valid[ch] = 1'b1;
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic bs, input logic [SW-1:0] bl,
                      input logic [NC-1:0] cc, input logic ca);
    logic exp_rdy;
    logic acc;
    int   ch;
    @(negedge clk);
    reset = r; wr_valid = v; wr_data = d; wr_sel = s;
    burst_start = bs; burst_len = bl; clr_ch = cc; clr_all = ca;
    #1;
    exp_rdy = !r && (sweep_left == 0) &&
              !((burst_q.size() == 0) && (bs || ca)) && !((burst_q.size() != 0) && ca);
    chk("wr_ready", 128'(wr_ready), 128'(exp_rdy));
    ready_seen = wr_ready;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NC; k++) m_regs[k] = '0;
      m_valid = '0; m_err = 1'b0; burst_q.delete(); sweep_left = 0;
    end else begin
      m_err = 1'b0;
      acc = v && exp_rdy;
      if (ca && sweep_left == 0) begin
        burst_q.delete();
        sweep_left = NC;
      end else if (sweep_left != 0) begin
        ch = NC - sweep_left;
        m_regs[ch] = '0; m_valid[ch] = 1'b0;
        sweep_left--;
      end else if (burst_q.size() == 0 && bs) begin
        if (int'(s) < NC && bl != 0) begin
          for (int i = 0; i < int'(bl); i++) burst_q.push_back((int'(s) + i) % NC);
        end else m_err = 1'b1;
      end else if (acc) begin
        if (burst_q.size() != 0) m_write(burst_q.pop_front(), d);
        else if (int'(s) < NC)   m_write(int'(s), d);
        else                     m_err = 1'b1;
      end
      for (int k = 0; k < NC; k++) if (cc[k]) begin m_regs[k] = '0; m_valid[k] = 1'b0; end
    end
    #1;
    chk("regs", 128'(regs), 128'(model_regs()));
    chk("ch_valid", 128'(ch_valid), 128'(m_valid));
    chk("burst_busy", 128'(burst_busy), 128'(burst_q.size() != 0));
    chk("sel_err", 128'(sel_err), 128'(m_err));
  endtask

  typedef struct {
    logic          r, v;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          bs;
    logic [SW-1:0] bl;
    logic [NC-1:0] cc;
    logic          ca;
    logic          e_rdy, e_err, e_busy;
  } vec_t;

  vec_t tbl [13];
  int   zc;
  logic [NC*DW-1:0] ev;

  initial begin
    for (int k = 0; k < NC; k++) m_regs[k] = '0;
    //            r  v  d      s   bs  bl  cc  ca  rdy err busy
    tbl[0]  = '{1, 0, 8'h00, 0,  0, 0,  0,  0,  0,  0,  0};
    tbl[1]  = '{0, 1, 8'h11, 0,  0, 0,  0,  0,  1,  0,  0};
    tbl[2]  = '{0, 1, 8'h99, 9,  0, 0,  0,  0,  1,  0,  0};
    tbl[3]  = '{0, 1, 8'hAB, 12, 0, 0,  0,  0,  1,  1,  0};
    tbl[4]  = '{0, 0, 8'h00, 0,  0, 0,  0,  0,  1,  0,  0};
    tbl[5]  = '{0, 0, 8'h00, 8,  1, 4,  0,  0,  0,  0,  1};
    tbl[6]  = '{0, 1, 8'hA0, 3,  0, 0,  0,  0,  1,  0,  1};
    tbl[7]  = '{0, 1, 8'hA1, 3,  1, 2,  0,  0,  1,  0,  1};
    tbl[8]  = '{0, 1, 8'hA2, 3,  0, 0,  0,  0,  1,  0,  1};
    tbl[9]  = '{0, 1, 8'hA3, 3,  0, 0,  0,  0,  1,  0,  0};
    tbl[10] = '{0, 0, 8'h00, 3,  1, 0,  0,  0,  0,  1,  0};
    tbl[11] = '{0, 0, 8'h00, 10, 1, 2,  0,  0,  0,  1,  0};
    tbl[12] = '{0, 0, 8'h00, 0,  0, 0,  0,  0,  1,  0,  0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].bs, tbl[i].bl, tbl[i].cc, tbl[i].ca);
      chk($sformatf("tbl%0d_ready", i), 128'(ready_seen), 128'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_err", i), 128'(sel_err), 128'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 128'(burst_busy), 128'(tbl[i].e_busy));
      if (i == 2) begin
        chk("direct_ch0", 128'(regs[0*DW +: DW]), 128'(8'h11));
        chk("direct_ch9", 128'(regs[9*DW +: DW]), 128'(8'h99));
        chk("direct_valid", 128'(ch_valid), 128'(10'b10_0000_0001));
      end
    end
    chk("burst_ch8", 128'(regs[8*DW +: DW]), 128'(8'hA0));
    chk("burst_ch9", 128'(regs[9*DW +: DW]), 128'(8'hA1));
    chk("burst_ch0", 128'(regs[0*DW +: DW]), 128'(8'hA2));
    chk("burst_ch1", 128'(regs[1*DW +: DW]), 128'(8'hA3));
    chk("burst_valid", 128'(ch_valid), 128'(10'b11_0000_0011));

    // Load all, start a burst, abort it with clr_all and time the sweep.
    for (int c = 0; c < NC; c++) step(0, 1, 8'(c + 8'h30), 4'(c), 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 1, 5, 0, 0);
    step(0, 1, 8'hC0, 0, 0, 0, 0, 0);
    step(0, 1, 8'hC1, 0, 0, 0, 0, 0);
    step(0, 1, 8'h77, 0, 0, 0, 0, 1);
    zc = 0;
    for (int n = 0; n < 30; n++) begin
      step(0, 1, 8'h5A, 2, 0, 0, 0, 0);
      if (ready_seen) break;
      zc++;
    end
    chk("sweep_len", 128'(zc), 128'(10));
    ev = '0;
    ev[2*DW +: DW] = 8'h5A;
    chk("post_sweep_regs", 128'(regs), 128'(ev));
    chk("post_sweep_valid", 128'(ch_valid), 128'(10'b00_0000_0100));
    chk("post_sweep_busy", 128'(burst_busy), 128'(0));

    // Clear and write to the same channel on one edge.
    step(0, 1, 8'h44, 3, 0, 0, 0, 0);
    step(0, 1, 8'h55, 3, 0, 0, 10'b00_0000_1000, 0);
    chk("clr_ch3_reg", 128'(regs[3*DW +: DW]), 128'(0));
    chk("clr_ch3_valid", 128'(ch_valid[3]), 128'(0));

    // Clear wins over a burst beat, and the burst still advances.
    step(0, 0, 8'h00, 4, 1, 2, 0, 0);
    step(0, 1, 8'h61, 0, 0, 0, 10'b00_0001_0000, 0);
    step(0, 1, 8'h62, 0, 0, 0, 0, 0);
    chk("burst_clr_ch4", 128'(regs[4*DW +: DW]), 128'(0));
    chk("burst_clr_ch5", 128'(regs[5*DW +: DW]), 128'(8'h62));
    chk("burst_clr_done", 128'(burst_busy), 128'(0));

    // Reset in the middle of a burst.
    step(0, 0, 8'h00, 0, 1, 5, 0, 0);
    step(0, 1, 8'hE1, 0, 0, 0, 0, 0);
    step(1, 1, 8'hE2, 0, 0, 0, 0, 0);
    step(1, 1, 8'hE3, 0, 0, 0, 0, 0);
    chk("rst_ready", 128'(ready_seen), 128'(0));
    chk("rst_regs", 128'(regs), 128'(0));
    chk("rst_valid", 128'(ch_valid), 128'(0));
    chk("rst_busy", 128'(burst_busy), 128'(0));
    chk("rst_err", 128'(sel_err), 128'(0));
    step(0, 1, 8'h12, 1, 0, 0, 0, 0);
    chk("post_rst_write", 128'(regs[1*DW +: DW]), 128'(8'h12));

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7),
           8'($urandom),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0,
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/demux_regbank.md
Name: demux_regbank

Overview:
- Parametrised write-demultiplexer into a bank of N_CH registers of DATA_W bits.
- Next generation of the team's selector-driven register demux.
- Adds a valid/ready write handshake, out-of-range rejection with an error pulse, and an auto-increment burst mode with wrap.
- Adds per-channel clear, a multi-cycle clear-all sweep, and per-channel "written" flags.
- Sits between a byte-stream producer (UART/keypad decoder) and display/compute logic that reads the register bank in parallel.

Parameters:
- DATA_W, 8, width of each register and of wr_data.
- N_CH, 10, number of registers; 2 <= N_CH <= 2^SEL_W.
- SEL_W, 4, width of wr_sel and burst_len.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  beat accepted on an edge where wr_valid && wr_ready.
- wr_data  in  DATA_W  beat data.
- wr_sel  in  SEL_W  target channel (direct mode); base channel when burst_start is high.
- burst_start  in  1  begin burst at channel wr_sel.
- burst_len  in  SEL_W  number of beats in the burst (1..2^SEL_W-1).
- clr_ch  in  N_CH  per-channel synchronous clear, one bit per channel.
- clr_all  in  1  start a clear-all sweep.
- regs  out  N_CH*DATA_W  register bank, flattened; channel k at bits [k*DATA_W +: DATA_W].
- ch_valid  out  N_CH  bit k set when channel k has been written since its last clear/reset.
- burst_busy  out  1  high while in BURST.
- sel_err  out  1  one-cycle registered error pulse.

Behaviour:
- Reset: the reset signal is synchronous, active-high; clock is clk.
  - Values while reset is high: regs=0, ch_valid=0, state=IDLE, burst_busy=0, sel_err=0, wr_ready=0.
- Priority on every edge, highest first: reset > clr_all > burst_start > write beat.
- wr_ready (combinational) = !reset && state!=SWEEP && !(state==IDLE && (burst_start || clr_all)).
  - In BURST it is forced to 0 only when clr_all is high.
- Latency: an accepted beat appears on regs and ch_valid the cycle after the accepting edge.
- FSM states: IDLE, BURST, SWEEP.
- IDLE, direct mode:
  - Accepted beat with wr_sel < N_CH writes reg[wr_sel]=wr_data and sets ch_valid[wr_sel].
  - Accepted beat with wr_sel >= N_CH is dropped; no register changes; sel_err=1 next cycle.
- IDLE, burst_start=1:
  - Valid case (wr_sel < N_CH and burst_len != 0): latch ptr=wr_sel and cnt=burst_len, go to BURST. No beat is consumed that cycle.
  - Invalid case (wr_sel >= N_CH or burst_len == 0): stay in IDLE and pulse sel_err.
- BURST:
  - Each accepted beat writes reg[ptr] and sets ch_valid[ptr].
  - ptr increments, wrapping from N_CH-1 to 0; cnt decrements.
  - The beat taken when cnt==1 returns the FSM to IDLE on that edge.
  - burst_len > N_CH is legal: the pointer wraps and overwrites earlier channels in order.
  - wr_sel and burst_start are ignored in BURST.
- clr_all:
  - Accepted in IDLE or BURST; aborts a burst in progress, discarding remaining cnt.
  - Go to SWEEP with sweep counter sc=0.
  - Ignored while already in SWEEP.
- SWEEP:
  - Each cycle clears reg[sc] and ch_valid[sc], then increments sc.
  - After channel N_CH-1 is cleared, return to IDLE: N_CH cycles total with wr_ready=0.
  - A beat arriving during SWEEP is not accepted; the producer holds it.
- clr_ch:
  - Active in any state; clears the flagged channels on that edge.
  - If the same channel is also written on that edge, the clear wins and the beat is still counted as accepted (ptr/cnt advance).
- sel_err is never held; back-to-back errors produce back-to-back pulses.
- Registers not targeted keep their value; there is no default-channel write.

Test Plan:
- Reset, then direct beats (sel=0, 8'h11), (sel=9, 8'h99) -> ch0=8'h11, ch9=8'h99, ch_valid=10'b10_0000_0001, sel_err stays 0.
- Direct beat sel=12, data 8'hAB -> all regs unchanged, sel_err high exactly one cycle, wr_ready stays 1.
- burst_start with sel=8, len=4, then beats 8'hA0..8'hA3 -> ch8=A0, ch9=A1, ch0=A2, ch1=A3.
  - burst_busy high from the edge after burst_start until the 4th beat edge; wr_ready=0 in the burst_start cycle.
- burst_start with len=0, and separately with sel=10 -> FSM stays IDLE, sel_err pulses each time, no writes.
- Load all channels, start a burst of len=5, assert clr_all after 2 beats -> wr_ready=0 for exactly 10 cycles.
  - All regs and ch_valid are 0 afterwards; state is IDLE; the next direct beat is accepted.
- clr_ch=10'b00_0000_1000 on the same edge as a direct write to sel=3 -> ch3=0, ch_valid[3]=0.
  - Assert reset mid-burst -> all outputs at reset values, state IDLE.
